sdram_port_arbiter: RTL

Shares one EasySDRAM command FIFO among NPORTS independent requesters. It sits between client logic and EasySDRAM: it arbitrates write/read commands round-robin, holds a grant for short same-row bursts to avoid row thrash, and routes in-order read returns back to the issuing port via a tag FIFO.

---
 rtl/sdram_arb_pkg.sv | 28 ++
 rtl/sdram_tag_fifo.sv | 53 +++++
 rtl/sdram_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the EasySDRAM port arbiter: field widths, command struct, FSM states.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package sdram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int MASK_W = 2;
    localparam int COL_W  = 10;
    localparam int ROW_W  = ADDR_W - COL_W;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] write_mask;
        logic [DATA_W-1:0] write_data;
    } sd_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:COL_W];
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// First-word-fall-through register FIFO holding the issuing port of each outstanding read.
// Latency: head_dat valid combinationally while !empty; push visible at head the cycle after.
// Backpressure: push ignored when full, pop ignored when empty; caller checks full/empty.
// Ports: clk, rst_n (sync, active-low), push/push_dat, pop, head_dat, count, empty, full.
module sdram_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one EasySDRAM command FIFO among NPORTS clients, with same-row burst hold and read-return routing.
// Latency: 0 cycles req_valid->req_ready/sd_write and sd_readValid->rsp_valid; arbitration state updates at the clock edge.
// Backpressure: sd_full or a full tag FIFO (reads) stalls the grantee, which keeps its grant; responses cannot be stalled.
// Ports: req_* per-port command bus, rsp_* one-hot read return, sd_* EasySDRAM FIFO/read port, grantPort/badMask/tagUnderflow status.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int MAX_BURST = 8,
    parameter int TAG_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NPORTS-1:0]           req_valid,
    output logic [NPORTS-1:0]           req_ready,
    input  logic [NPORTS-1:0]           req_isWrite,
    input  logic [NPORTS*ADDR_W-1:0]    req_address,
    input  logic [NPORTS*MASK_W-1:0]    req_writeMask,
    input  logic [NPORTS*DATA_W-1:0]    req_writeData,
    output logic [NPORTS-1:0]           rsp_valid,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        sd_write,
    output logic                        sd_isWrite,
    output logic [ADDR_W-1:0]           sd_address,
    output logic [MASK_W-1:0]           sd_writeMask,
    output logic [DATA_W-1:0]           sd_writeData,
    input  logic                        sd_full,
    input  logic                        sd_readValid,
    input  logic [ADDR_W-1:0]           sd_raddr,
    input  logic [DATA_W-1:0]           sd_rdata,
    output logic [$clog2(NPORTS)-1:0]   grantPort,
    output logic                        badMask,
    output logic                        tagUnderflow
);
    localparam int PW = $clog2(NPORTS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TAG_DEPTH) + 1;

    sd_cmd_t          cmd [NPORTS];
    sd_cmd_t          gnt_cmd;

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    hold_q, hold_d;
    logic [ROW_W-1:0] last_row_q, last_row_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic             bad_q, bad_d;
    logic             unf_q, unf_d;

    logic             hold_alive;
    logic             hold_hit;
    logic             rr_found;
    logic [PW-1:0]    rr_idx;
    logic             gnt_vld;
    logic [PW-1:0]    gnt_idx;
    logic             blocked;
    logic             accept;
    logic             drop;

    logic [PW-1:0]    tag_head;
    logic [TW-1:0]    tag_count;
    logic             tag_empty;
    logic             tag_full;
    logic             tag_push;
    logic             tag_pop;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            cmd[p].is_write   = req_isWrite[p];
            cmd[p].address    = req_address[ADDR_W*p +: ADDR_W];
            cmd[p].write_mask = req_writeMask[MASK_W*p +: MASK_W];
            cmd[p].write_data = req_writeData[DATA_W*p +: DATA_W];
        end
    end

    // Arbitration: keep the holder while it streams to the same row and
    // has burst budget left, otherwise first valid port upward from rr_q.
    always_comb begin
        hold_alive = (state_q == ST_HOLD) && req_valid[hold_q]
                     && (row_of(cmd[hold_q].address) == last_row_q);
        hold_hit   = hold_alive && (burst_q < BW'(MAX_BURST));
        rr_found   = 1'b0;
        rr_idx     = '0;
        for (int i = 0; i < NPORTS; i++) begin
            int k;
            k = (int'(rr_q) + i) % NPORTS;
            if (!rr_found && req_valid[k]) begin
                rr_found = 1'b1;
                rr_idx   = PW'(k);
            end
        end
        gnt_vld = hold_hit || rr_found;
        gnt_idx = hold_hit ? hold_q : rr_idx;
        gnt_cmd = cmd[gnt_idx];
        // A stalled grantee is not bypassed, so lower-priority ports wait too.
        blocked = sd_full || (!gnt_cmd.is_write && (tag_count == TW'(TAG_DEPTH)));
        accept  = rst_n && gnt_vld && !blocked;
        // Empty-mask writes are consumed but never reach the SDRAM.
        drop    = gnt_cmd.is_write && (gnt_cmd.write_mask == '0);
    end

    assign tag_push = accept && !gnt_cmd.is_write && !tag_full;
    assign tag_pop  = rst_n && sd_readValid && !tag_empty;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (PW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push),
        .push_dat (gnt_idx),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .count    (tag_count),
        .empty    (tag_empty),
        .full     (tag_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            last_row_q <= '0;
            burst_q    <= '0;
            rr_q       <= '0;
            bad_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_row_q <= last_row_d;
            burst_q    <= burst_d;
            rr_q       <= rr_d;
            bad_q      <= bad_d;
            unf_q      <= unf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_row_d = last_row_q;
        burst_d    = burst_q;
        rr_d       = rr_q;
        bad_d      = bad_q || (accept && drop);
        unf_d      = unf_q || (sd_readValid && tag_empty);
        if (accept) begin
            state_d    = ST_HOLD;
            hold_d     = gnt_idx;
            last_row_d = row_of(gnt_cmd.address);
            // A round-robin grant starts a fresh burst even if it picks the old holder.
            burst_d    = hold_hit ? burst_q + 1'b1 : BW'(1);
            rr_d       = (gnt_idx == PW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (!hold_alive) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        sd_write     = 1'b0;
        sd_isWrite   = gnt_cmd.is_write;
        sd_address   = gnt_cmd.address;
        sd_writeMask = gnt_cmd.write_mask;
        sd_writeData = gnt_cmd.write_data;
        rsp_addr     = sd_raddr;
        rsp_data     = sd_rdata;
        badMask      = bad_q;
        tagUnderflow = unf_q;
        grantPort    = rst_n ? (gnt_vld ? gnt_idx : hold_q) : '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
            sd_write           = !drop;
        end
        if (tag_pop) rsp_valid[tag_head] = 1'b1;
    end

endmodule
